// File: rtl/lut_cmul_pkg.sv
// lut_cmul_pkg: shared widths, saturation constants and helper functions for
// the runtime-coefficient pipelined multiplier (lut_cmul_pipe).
package lut_cmul_pkg;

  // Width of the saturation event counter and its ceiling value.
  localparam int SAT_CNT_W = 16;
  localparam logic [SAT_CNT_W-1:0] SAT_CNT_MAX = '1;

  // Signed clamp limits for a given output width, held at 64 bits so they can
  // be compared directly against a sign-extended full-width product.
  typedef struct packed {
    logic signed [63:0] min_v;
    logic signed [63:0] max_v;
  } sat_bounds_t;

  // Full-precision width of a DATA_W x COEF_W signed product.
  function automatic int prod_w(input int data_w, input int coef_w);
    return data_w + coef_w;
  endfunction

  // Most negative and most positive values representable in out_w bits.
  function automatic sat_bounds_t sat_bounds(input int out_w);
    sat_bounds_t b;
    b.max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    b.min_v = -(64'sd1 <<< (out_w - 1));
    return b;
  endfunction

endpackage

// File: rtl/lut_cmul_pp.sv
// lut_cmul_pp: one signed partial product of a shift-and-add multiplier.
// The coefficient bit position and whether it is the (negatively weighted)
// two's complement sign bit are fixed at elaboration time, so each instance
// reduces to a mux between zero and a shifted, possibly negated, operand.
module lut_cmul_pp
  import lut_cmul_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int COEF_W  = 4,
  parameter int BIT_IDX = 0,
  parameter bit IS_MSB  = 1'b0,
  localparam int PW     = prod_w(DATA_W, COEF_W)
) (
  input  logic signed [DATA_W-1:0] data,
  input  logic                     coef_bit,
  output logic signed [PW-1:0]     pp
);

  logic signed [PW-1:0] data_ext;
  logic signed [PW-1:0] shifted;

  // Sign-extend, weight by 2^BIT_IDX, and negate when this is the sign bit.
  always_comb begin
    data_ext = {{(PW-DATA_W){data[DATA_W-1]}}, data};
    shifted  = data_ext <<< BIT_IDX;
    if (!coef_bit) begin
      pp = '0;
    end else if (IS_MSB) begin
      pp = -shifted;
    end else begin
      pp = shifted;
    end
  end

endmodule

// File: rtl/lut_cmul_pipe.sv
// lut_cmul_pipe: pipelined signed multiplier, DATA_W-bit operand times a
// per-beat COEF_W-bit coefficient, valid/ready on both sides, tag passthrough.
// Stages: S1 input register, S2 partial-sum register, S3 full product
// register, then the narrowed output register. The whole pipe advances
// together whenever the output register is empty or being drained.
// Optional feature macro: LUT_CMUL_SAT_EN (clamp to OUT_W and count clamps);
// when undefined the product wraps to OUT_W and sat_cnt is tied to zero.
module lut_cmul_pipe
  import lut_cmul_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int COEF_W = 4,
  parameter int OUT_W  = DATA_W + COEF_W,
  parameter int TAG_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [COEF_W-1:0]    in_coef,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic [TAG_W-1:0]     out_tag,
  output logic [SAT_CNT_W-1:0] sat_cnt
);

  localparam int PW   = prod_w(DATA_W, COEF_W);
  localparam int LO_N = COEF_W / 2;

  logic                     adv;

  logic                     s1_valid;
  logic signed [DATA_W-1:0] s1_data;
  logic [COEF_W-1:0]        s1_coef;
  logic [TAG_W-1:0]         s1_tag;

  logic signed [PW-1:0]     pp [COEF_W];
  logic signed [PW-1:0]     sum_lo;
  logic signed [PW-1:0]     sum_hi;

  logic                     s2_valid;
  logic signed [PW-1:0]     s2_lo;
  logic signed [PW-1:0]     s2_hi;
  logic [TAG_W-1:0]         s2_tag;

  logic                     s3_valid;
  logic signed [PW-1:0]     s3_prod;
  logic [TAG_W-1:0]         s3_tag;

  logic [OUT_W-1:0]         narrow_data;

  // Bubbles are not collapsed: a full, stalled output freezes every stage.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar i = 0; i < COEF_W; i++) begin : g_pp
    lut_cmul_pp #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .BIT_IDX(i),
      .IS_MSB (i == COEF_W - 1)
    ) u_pp (
      .data    (s1_data),
      .coef_bit(s1_coef[i]),
      .pp      (pp[i])
    );
  end

  // Reduce the partial products into a low-index and a high-index sum.
  always_comb begin
    sum_lo = '0;
    sum_hi = '0;
    for (int i = 0; i < COEF_W; i++) begin
      if (i < LO_N) begin
        sum_lo = sum_lo + pp[i];
      end else begin
        sum_hi = sum_hi + pp[i];
      end
    end
  end

  // Pipeline registers: all stages move together on adv, all valids clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_coef   <= '0;
      s1_tag    <= '0;
      s2_valid  <= 1'b0;
      s2_lo     <= '0;
      s2_hi     <= '0;
      s2_tag    <= '0;
      s3_valid  <= 1'b0;
      s3_prod   <= '0;
      s3_tag    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_data   <= in_data;
      s1_coef   <= in_coef;
      s1_tag    <= in_tag;
      s2_valid  <= s1_valid;
      s2_lo     <= sum_lo;
      s2_hi     <= sum_hi;
      s2_tag    <= s1_tag;
      s3_valid  <= s2_valid;
      s3_prod   <= s2_lo + s2_hi;
      s3_tag    <= s2_tag;
      out_valid <= s3_valid;
      out_data  <= narrow_data;
      out_tag   <= s3_tag;
    end
  end

`ifdef LUT_CMUL_SAT_EN

  localparam sat_bounds_t        BOUNDS  = sat_bounds(OUT_W);
  localparam logic signed [63:0] SAT_MIN = BOUNDS.min_v;
  localparam logic signed [63:0] SAT_MAX = BOUNDS.max_v;
  localparam logic [OUT_W-1:0]   MIN_Q   = SAT_MIN[OUT_W-1:0];
  localparam logic [OUT_W-1:0]   MAX_Q   = SAT_MAX[OUT_W-1:0];

  logic signed [63:0]     prod_ext;
  logic                   narrow_sat;
  logic                   out_sat;
  logic [SAT_CNT_W-1:0]   sat_cnt_q;

  assign prod_ext = {{(64-PW){s3_prod[PW-1]}}, s3_prod};

  // Clamp to the OUT_W range; with OUT_W equal to the full width this never fires.
  always_comb begin
    narrow_sat  = 1'b0;
    narrow_data = s3_prod[OUT_W-1:0];
    if (prod_ext > SAT_MAX) begin
      narrow_data = MAX_Q;
      narrow_sat  = 1'b1;
    end else if (prod_ext < SAT_MIN) begin
      narrow_data = MIN_Q;
      narrow_sat  = 1'b1;
    end
  end

  // Clamp flag travels with the result so it can be counted at its handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sat <= 1'b0;
    end else if (adv) begin
      out_sat <= s3_valid && narrow_sat;
    end
  end

  // Count clamped results as they leave, sticking at the counter ceiling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q <= '0;
    end else if (out_valid && out_ready && out_sat && (sat_cnt_q != SAT_CNT_MAX)) begin
      sat_cnt_q <= sat_cnt_q + 1'b1;
    end
  end

  assign sat_cnt = sat_cnt_q;

`else

  // Plain two's complement wrap: keep the low OUT_W bits of the product.
  always_comb begin
    narrow_data = s3_prod[OUT_W-1:0];
  end

  if (OUT_W < PW) begin : g_wrap_drop
    logic unused_hi_bits;
    assign unused_hi_bits = ^s3_prod[PW-1:OUT_W];
  end

  assign sat_cnt = '0;

`endif

endmodule
